rx_control_module: RTL and testbench

UART receive controller that sequences one 8N1 frame (parameterisable data width) per detected start edge. It sits downstream of the start-edge detector, which supplies a one-cycle high-to-low pulse, and beside the synchronised RX line. It owns the bit-timing counter, the bit-centre sampling schedule, the data shift register, and the frame-completion and error handshakes delivered to the consumer.

---
 rtl/rx_control_module.sv | 150 +++++++++++++++
 tb/tb_rx_control_module.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rx_control_module.sv
// UART receive controller: sequences one start/data/[parity]/stop frame per start edge.
// Optional parity checking is enabled by defining RX_PARITY_EN.
module rx_control_module #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLOCK,
  input  logic                 RST_n,
  input  logic                 H2L_Sig,
  input  logic                 RX_Pin_In,
  input  logic                 RX_En_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 Frame_Err,
  output logic                 Parity_Err,
  output logic                 Busy
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int IW      = $clog2(DATA_BITS + 1);

  // START enters with the counter at 0 in cycle t=1, so its sample fires at HALF-1.
  localparam logic [CW-1:0] CNT_START = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  logic                 r_done;
  logic                 r_ferr;
  logic                 r_perr;

  logic                 w_tick;
  logic                 w_par_exp;
  logic [DATA_BITS-1:0] w_shift_nxt;

  always_comb begin
    w_tick = 1'b0;
    if (r_state == S_START)
      w_tick = (r_cnt == CNT_START);
    else if (r_state != S_IDLE)
      w_tick = (r_cnt == CNT_LAST);
  end

  always_comb begin
    w_shift_nxt = r_shift;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (r_idx == IW'(i))
        w_shift_nxt[i] = RX_Pin_In;
    end
  end

  assign w_par_exp = (^r_shift) ^ PARITY_ODD[0];

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      RX_Data   <= '0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;

      if (r_state == S_IDLE || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (H2L_Sig && RX_En_Sig) begin
            r_state   <= S_START;
            r_idx     <= '0;
            r_par_bad <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick)
            r_state <= RX_Pin_In ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= w_shift_nxt;
            if (r_idx == IDX_LAST) begin
`ifdef RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par_bad <= (RX_Pin_In != w_par_exp);
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            // A parity failure still reports a bad stop bit alongside it.
            if (r_par_bad) begin
              r_perr  <= 1'b1;
              r_ferr  <= ~RX_Pin_In;
              r_state <= S_IDLE;
            end else if (!RX_Pin_In) begin
              r_ferr  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              RX_Data <= r_shift;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RX_Done_Sig = r_done;
  assign Frame_Err   = r_ferr;
  assign Parity_Err  = r_perr;
  assign Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rx_control_module.sv
// Self-checking bench for rx_control_module: directed plan cases plus randomized frames
// checked cycle by cycle against a timing model derived from the frame schedule.
module tb_rx_control_module;

  localparam int BC   = 16;
  localparam int HALF = 8;
  localparam int DB   = 8;

  logic          CLOCK = 1'b0;
  logic          RST_n = 1'b0;
  logic          H2L_Sig = 1'b0;
  logic          RX_Pin_In = 1'b1;
  logic          RX_En_Sig = 1'b0;
  logic [DB-1:0] RX_Data;
  logic          RX_Done_Sig;
  logic          Frame_Err;
  logic          Parity_Err;
  logic          Busy;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DB-1:0] exp_data = '0;
  logic [DB-1:0] exp_q[$];

  rx_control_module #(
    .CLK_FREQ(16), .BAUD(1), .DATA_BITS(DB), .PARITY_ODD(0)
  ) dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .H2L_Sig(H2L_Sig), .RX_Pin_In(RX_Pin_In),
    .RX_En_Sig(RX_En_Sig), .RX_Data(RX_Data), .RX_Done_Sig(RX_Done_Sig),
    .Frame_Err(Frame_Err), .Parity_Err(Parity_Err), .Busy(Busy)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(RX_Done_Sig), 0);
    chk({tag, "_ferr"}, 32'(Frame_Err), 0);
    chk({tag, "_perr"}, 32'(Parity_Err), 0);
    chk({tag, "_data"}, 32'(RX_Data), 0);
  endtask

  // One frame starting at t=0. The model only knows the bit schedule: bit k of the
  // frame occupies cycles 16k..16k+15 and is judged at its centre HALF+16k.
  task automatic run_frame(input logic [DB-1:0] data, input bit stop_b, input bit par_b,
                           input bit false_st, input int en_drop, input int rst_at,
                           input bit noise);
    bit   seq[$];
    int   nb, ts, te;
    bit   par_used, par_ok, good, ferr, perr;
    logic line;
    seq.push_back(1'b0);
    for (int i = 0; i < DB; i++) seq.push_back(data[i]);
`ifdef RX_PARITY_EN
    par_used = 1'b1;
    seq.push_back(par_b);
`else
    par_used = 1'b0;
`endif
    seq.push_back(stop_b);
    nb     = seq.size();
    par_ok = !par_used || (par_b == ((^data) ^ 1'b0));
    if (false_st) begin
      ts = HALF; good = 0; ferr = 0; perr = 0;
    end else begin
      ts = HALF + (nb - 1) * BC;
      perr = !par_ok;
      ferr = !stop_b;
      good = stop_b && par_ok;
    end
    te = ts + 1;
    if (good) exp_q.push_back(data);

    @(negedge CLOCK);
    H2L_Sig = 1'b1; RX_En_Sig = 1'b1; RX_Pin_In = 1'b0;
    for (int t = 1; t <= te + 2; t++) begin
      @(negedge CLOCK);
      chk("busy", 32'(Busy), 32'((t <= ts) || (good && t == te)));
      chk("done", 32'(RX_Done_Sig), 32'(good && t == te));
      chk("frame_err", 32'(Frame_Err), 32'(ferr && t == te));
      chk("parity_err", 32'(Parity_Err), 32'(perr && t == te));
      if (good && t >= te) chk("rx_data", 32'(RX_Data), 32'(exp_q[0]));
      else                 chk("rx_data", 32'(RX_Data), 32'(exp_data));
      if (false_st) line = (t < 3) ? 1'b0 : 1'b1;
      else          line = (t / BC < nb) ? seq[t / BC] : 1'b1;
      RX_Pin_In = line;
      H2L_Sig   = noise && (t < ts) && ($urandom_range(7) == 0);
      if (en_drop >= 0 && t >= en_drop) RX_En_Sig = 1'b0;
      else if (noise)                   RX_En_Sig = 1'($urandom_range(1));
      else                              RX_En_Sig = 1'b1;
      if (t == rst_at) begin
        #2 RST_n = 1'b0;
        H2L_Sig = 1'b0; RX_Pin_In = 1'b1;
        #1 chk_all_zero("async_rst");
        if (good) void'(exp_q.pop_back());
        exp_data = '0;
        repeat (2) @(negedge CLOCK);
        RST_n = 1'b1;
        return;
      end
    end
    H2L_Sig = 1'b0; RX_Pin_In = 1'b1;
    if (good) exp_data = exp_q.pop_front();
    repeat ($urandom_range(3, 1)) @(negedge CLOCK);
  endtask

  initial begin
    RST_n = 1'b0;
    repeat (2) @(negedge CLOCK);
    chk_all_zero("reset");
    RST_n = 1'b1;
    @(negedge CLOCK);

    run_frame(8'hA5, 1, 1, 0, -1, -1, 0);
    run_frame(8'h00, 1, 0, 1, -1, -1, 0);
    run_frame(8'h3C, 0, 0, 0, -1, -1, 0);

    // Enable low on a start edge: the edge must be ignored.
    @(negedge CLOCK);
    H2L_Sig = 1'b1; RX_En_Sig = 1'b0; RX_Pin_In = 1'b0;
    @(negedge CLOCK);
    H2L_Sig = 1'b0; RX_Pin_In = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("en_low_busy", 32'(Busy), 0);
      @(negedge CLOCK);
    end

    run_frame(8'h81, 1, 0, 0, 40, -1, 0);
    run_frame(8'h33, 1, 0, 0, -1, 70, 0);
    run_frame(8'h5A, 1, 0, 0, -1, -1, 0);

`ifdef RX_PARITY_EN
    run_frame(8'h07, 1, 1, 0, -1, -1, 0);
    run_frame(8'h07, 1, 0, 0, -1, -1, 0);
    run_frame(8'h07, 0, 0, 0, -1, -1, 0);
    run_frame(8'hF0, 1, 0, 0, -1, -1, 0);
`endif

    for (int n = 0; n < 24; n++) begin
      run_frame(8'($urandom_range(255)), ($urandom_range(3) != 0),
                1'($urandom_range(1)), ($urandom_range(7) == 0), -1, -1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
